// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The optional sub line exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output in_valid, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
      output sub,
`endif
      output out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
      input  sub,
`endif
      input  out_ready,
      output in_ready, out_valid, sum, cout
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one mux-built full-adder cell reused LSB first.
// Define SERIAL_ADD_SUB_EN to add a subtract mode (a - b) selected per operation.
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input logic              clk,
   input logic              rst_n,
   serial_add_ctrl_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_nxt;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             out_valid_q;
   logic             fa_p;
   logic             fa_sum;
   logic             fa_carry;
   logic [WIDTH-1:0] b_cap;
   logic             carry_cap;

   // Full-adder cell built from 2:1 muxes around the propagate term.
   assign fa_p     = a_sh[0] ^ b_sh[0];
   assign fa_sum   = carry ? ~fa_p : fa_p;
   assign fa_carry = fa_p ? carry : a_sh[0];

   // New sum bit enters at the MSB; written as a shift so WIDTH=1 is legal.
   assign sum_nxt = (sum_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
   assign b_cap     = bus.sub ? ~bus.b : bus.b;
   assign carry_cap = bus.sub ? 1'b1 : bus.cin;
`else
   assign b_cap     = bus.b;
   assign carry_cap = bus.cin;
`endif

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_sh        <= '0;
         b_sh        <= '0;
         sum_sh      <= '0;
         carry       <= 1'b0;
         cnt         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sh   <= bus.a;
                  b_sh   <= b_cap;
                  carry  <= carry_cap;
                  cnt    <= '0;
                  sum_sh <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               sum_sh <= sum_nxt;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= fa_carry;
               cnt    <= cnt + CNT_W'(1);
               // Last bit: publish the result directly into the output registers.
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  sum_q       <= sum_nxt;
                  cout_q      <= fa_carry;
                  out_valid_q <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances.
// Exercises subtract mode when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic [8:0] q8[$];
   logic [1:0] q1[$];

   logic       prev_hold8 = 1'b0;
   logic [7:0] prev_sum8;
   logic       prev_cout8;

   serial_add_ctrl_if #(.WIDTH(8)) i8 ();
   serial_add_ctrl_if #(.WIDTH(1)) i1 ();

   serial_add_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8));
   serial_add_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference result: plain integer arithmetic, {cout, sum}.
   function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
      logic [8:0] r;
      if (sub) r = 9'(a) + 9'(8'(~b)) + 9'd1;
      else     r = 9'(a) + 9'(b) + 9'(cin);
      return r;
   endfunction

   // Monitor for the 8-bit instance: stability while stalled, pop on handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_hold8 = 1'b0;
      end else begin
         if (i8.out_valid) begin
            if (prev_hold8) begin
               chk("stall_sum_stable", 32'(i8.sum), 32'(prev_sum8));
               chk("stall_cout_stable", 32'(i8.cout), 32'(prev_cout8));
            end
            if (i8.out_ready) begin
               if (q8.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL w8_unexpected_result: got 0x%0h with empty scoreboard", {i8.cout, i8.sum});
               end else begin
                  chk("w8_result", 32'({i8.cout, i8.sum}), 32'(q8.pop_front()));
               end
            end
         end
         prev_hold8 = i8.out_valid && !i8.out_ready;
         prev_sum8  = i8.sum;
         prev_cout8 = i8.cout;
      end
   end

   // Monitor for the 1-bit instance.
   always @(negedge clk) begin
      if (rst_n && i1.out_valid && i1.out_ready) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL w1_unexpected_result: got 0x%0h with empty scoreboard", {i1.cout, i1.sum});
         end else begin
            chk("w1_result", 32'({i1.cout, i1.sum}), 32'(q1.pop_front()));
         end
      end
   end

   // One full 8-bit operation with cycle-accurate handshake checks.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input int stall);
      q8.push_back(model8(a, b, cin, sub));
      @(posedge clk); #1;
      i8.a = a; i8.b = b; i8.cin = cin;
`ifdef SERIAL_ADD_SUB_EN
      i8.sub = sub;
`endif
      i8.in_valid  = 1'b1;
      i8.out_ready = (stall == 0);
      @(negedge clk);
      chk("idle_in_ready", 32'(i8.in_ready), 32'd1);
      @(posedge clk); #1;
      i8.a = 8'($urandom); i8.b = 8'($urandom); i8.cin = 1'($urandom);
      i8.in_valid = 1'($urandom);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("run_in_ready", 32'(i8.in_ready), 32'd0);
         chk("run_out_valid", 32'(i8.out_valid), 32'd0);
         @(posedge clk); #1;
         i8.in_valid = 1'($urandom);
      end
      @(negedge clk);
      chk("hold_out_valid", 32'(i8.out_valid), 32'd1);
      chk("hold_in_ready", 32'(i8.in_ready), 32'd0);
      if (stall > 0) begin
         for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            i8.in_valid = 1'($urandom);
            @(negedge clk);
            chk("stall_out_valid", 32'(i8.out_valid), 32'd1);
            chk("stall_in_ready", 32'(i8.in_ready), 32'd0);
         end
         @(posedge clk); #1;
         i8.out_ready = 1'b1;
         i8.in_valid  = 1'b0;
         @(negedge clk);
         chk("ack_out_valid", 32'(i8.out_valid), 32'd1);
      end
      @(posedge clk); #1;
      i8.in_valid = 1'b0;
      @(negedge clk);
      chk("post_out_valid", 32'(i8.out_valid), 32'd0);
      chk("post_in_ready", 32'(i8.in_ready), 32'd1);
   endtask

   // One 1-bit operation: result two cycles after the accept edge.
   task automatic op1(input logic a, input logic b, input logic cin);
      q1.push_back(2'(a) + 2'(b) + 2'(cin));
      @(posedge clk); #1;
      i1.a = a; i1.b = b; i1.cin = cin; i1.in_valid = 1'b1;
      @(posedge clk); #1;
      i1.in_valid = 1'b0;
      @(negedge clk);
      chk("w1_run_out_valid", 32'(i1.out_valid), 32'd0);
      @(negedge clk);
      chk("w1_hold_out_valid", 32'(i1.out_valid), 32'd1);
      @(negedge clk);
      chk("w1_post_out_valid", 32'(i1.out_valid), 32'd0);
      chk("w1_post_in_ready", 32'(i1.in_ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      i8.in_valid = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0; i8.out_ready = 1'b1;
      i1.in_valid = 1'b0; i1.a = '0; i1.b = '0; i1.cin = 1'b0; i1.out_ready = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
      i8.sub = 1'b0;
      i1.sub = 1'b0;
`endif
      #12;
      chk("rst_in_ready", 32'(i8.in_ready), 32'd1);
      chk("rst_out_valid", 32'(i8.out_valid), 32'd0);
      chk("rst_sum", 32'({i8.cout, i8.sum}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      op8(8'h35, 8'h4A, 1'b0, 1'b0, 0);
      op8(8'hFF, 8'h01, 1'b0, 1'b0, 0);
      op8(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
      op8(8'h00, 8'h00, 1'b0, 1'b0, 0);
      op8(8'h9C, 8'h27, 1'b1, 1'b0, 5);

      // Abort mid-RUN at bit 3.
      @(posedge clk); #1;
      i8.a = 8'hAA; i8.b = 8'h55; i8.cin = 1'b1; i8.in_valid = 1'b1;
      @(posedge clk); #1;
      i8.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(i8.out_valid), 32'd0);
      chk("abort_sum", 32'(i8.sum), 32'd0);
      chk("abort_cout", 32'(i8.cout), 32'd0);
      chk("abort_in_ready", 32'(i8.in_ready), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 32'(i8.in_ready), 32'd1);
      op8(8'h01, 8'h02, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
      op8(8'h10, 8'h01, 1'b0, 1'b1, 0);
      op8(8'h00, 8'h01, 1'b1, 1'b1, 0);
`endif

      for (int n = 0; n < 30; n++) begin
         logic s;
`ifdef SERIAL_ADD_SUB_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         op8(8'($urandom), 8'($urandom), 1'($urandom), s, (n % 4 == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      op1(1'b1, 1'b1, 1'b1);
      for (int v = 0; v < 8; v++) begin
         logic [2:0] bits;
         bits = 3'(v);
         op1(bits[2], bits[1], bits[0]);
      end

      repeat (2) @(negedge clk);
      chk("w8_scoreboard_drained", 32'(q8.size()), 32'd0);
      chk("w1_scoreboard_drained", 32'(q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that time-shares one 1-bit full-adder cell (the team's mux-built full adder) to perform a WIDTH-bit add, one bit per clock, LSB first.
- Holds operand and result shift registers, a carry register, a bit counter and a 3-state FSM.
- Uses valid/ready handshakes on both sides.
- Sits between an operand producer and a result consumer wherever a ripple adder is too large.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  sum and cout are valid
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result
- cout  output  1  final carry-out

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; shift regs, carry reg and counter = 0.
  - sum=0, cout=0, out_valid=0.
- in_ready = (state==IDLE), combinational; it reads 1 while held in reset.
- IDLE:
  - On in_valid && in_ready at a clock edge: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0; go to RUN.
  - in_valid without in_ready is ignored; the producer must hold its data.
- RUN, each cycle:
  - Drive the full-adder cell with (a_sh[0], b_sh[0], carry).
  - sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}; a_sh and b_sh shift right, zero-filled.
  - carry<=fa_carry; cnt<=cnt+1.
  - When cnt==WIDTH-1: take that last bit, then go to HOLD.
- HOLD:
  - out_valid=1; sum=sum_sh; cout=carry. Both stay stable until the handshake completes.
  - On out_valid && out_ready: go to IDLE; out_valid drops the next cycle.
- Latency:
  - Accept edge at cycle 0; RUN occupies cycles 1..WIDTH.
  - out_valid is high from cycle WIDTH+1.
  - Minimum throughput is one operation per WIDTH+2 cycles. There is no back-to-back accept, because in_ready is low in HOLD.
- Boundaries:
  - WIDTH=1: a single RUN cycle.
  - Counter never wraps; it is cleared on accept.
  - out_ready already high on entry to HOLD: out_valid is still high for exactly one cycle.
  - in_valid during RUN or HOLD has no effect.
  - Reset mid-RUN or mid-HOLD: the operation is aborted with no partial result visible and out_valid low; after release the block is in IDLE with in_ready=1.
- sum/cout are registered and hold their value after leaving HOLD until the next result replaces them. The consumer must not sample them without out_valid.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured on accept.
  - sub=1: b is inverted on capture and carry is initialised to 1; cin is ignored.
  - Result is a-b; cout=1 means no borrow.
  - sub=0 behaves exactly as the base block.
- Not defined: port sub is absent and the block performs add only.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, accept at cycle 0 -> out_valid at cycle 9, sum=0x7F, cout=0; in_ready low in cycles 1..9.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid rises -> sum/cout stable, in_valid pulses ignored, in_ready=0; out_ready=1 -> IDLE next cycle with in_ready=1.
- Reset: assert rst_n=0 during RUN at bit 3 -> out_valid=0, sum=0, cout=0 immediately; after release, accept a=0x01, b=0x02 -> sum=0x03.
- WIDTH=1 instance: a=1, b=1, cin=1 -> out_valid 2 cycles after accept, sum=1, cout=1.
- SERIAL_ADD_SUB_EN defined: sub=1, a=0x10, b=0x01 -> sum=0x0F, cout=1. Then sub=1, a=0x00, b=0x01 -> sum=0xFF, cout=0.
